// File: rtl/uart_defs.sv
// Shared UART definitions: arbiter state encoding and default sizing.
package uart_defs;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

    localparam int UART_N_REQ   = 4;
    localparam int UART_TIMEOUT = 1024;

    // Counter width that can hold values 0..limit without wrapping.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit at or above ptr, wrapping.
module rr_pick
    import uart_defs::*;
#(
    parameter int N_REQ = UART_N_REQ
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     any,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int IW = $clog2(N_REQ);

    // Walk from the farthest slot back to ptr so the nearest hit wins.
    always_comb begin
        int pos;
        any = 1'b0;
        idx = '0;
        pos = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k) % N_REQ;
            if (req[pos]) begin
                any = 1'b1;
                idx = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte requesters.
// state      | meaning
// IDLE       | waiting for a request with the transmitter idle
// LAUNCH     | gnt/tx_start/tx_data presented for one cycle
// WAIT_BUSY  | waiting for tx_busy to rise, bounded by TIMEOUT
// WAIT_DONE  | byte on the wire, waiting for tx_busy to fall
module uart_tx_arbiter
    import uart_defs::*;
#(
    parameter int N_REQ   = UART_N_REQ,
    parameter int TIMEOUT = UART_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    output logic                     done,
    output logic [$clog2(N_REQ)-1:0] done_id,
    output logic                     err,
    output logic                     busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = cnt_width(TIMEOUT);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     win_q, win_d;
    logic [7:0]        data_q, data_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [IW-1:0]     id_q, id_d;
    logic              busy_q, busy_d;

    logic              pick_any;
    logic [IW-1:0]     pick_idx;
    logic [7:0]        pick_byte;
    logic [N_REQ-1:0]  pick_onehot;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        pick_byte   = 8'h00;
        pick_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_byte      = req_data[8*i +: 8];
                pick_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        data_d  = data_q;
        cnt_d   = '0;
        gnt_d   = '0;
        start_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        id_d    = '0;

        unique case (state_q)
            ST_IDLE: begin
                // done_q blocks the decision so a grant never follows done back-to-back.
                if (!tx_busy && pick_any && !done_q) begin
                    state_d = ST_LAUNCH;
                    win_d   = pick_idx;
                    data_d  = pick_byte;
                    gnt_d   = pick_onehot;
                    start_d = 1'b1;
                    ptr_d   = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    id_d    = win_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    id_d    = win_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            data_q  <= 8'h00;
            cnt_q   <= '0;
            gnt_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            id_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            start_q <= start_d;
            done_q  <= done_d;
            err_q   <= err_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt      = gnt_q;
    assign tx_start = start_q;
    assign tx_data  = data_q;
    assign done     = done_q;
    assign done_id  = id_q;
    assign err      = err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, TIMEOUT=16).
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        done;
    logic [1:0]  done_id;
    logic        err;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .done     (done),
        .done_id  (done_id),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, "gnt", gnt, 0);
        chk(tag, "tx_start", tx_start, 0);
        chk(tag, "tx_data", tx_data, 0);
        chk(tag, "done", done, 0);
        chk(tag, "done_id", done_id, 0);
        chk(tag, "err", err, 0);
        chk(tag, "busy", busy, 0);
    endtask

    // Called with the arbiter in IDLE and free to decide at the next edge.
    task automatic xfer(input string tag, input logic [3:0] eg, input logic [7:0] eb,
                        input logic [1:0] eid, input int dly, input int len);
        tick();
        chk(tag, "gnt", gnt, eg);
        chk(tag, "tx_start", tx_start, 1);
        chk(tag, "tx_data", tx_data, eb);
        chk(tag, "busy", busy, 1);
        tick();
        chk(tag, "gnt_pulse", gnt, 0);
        chk(tag, "start_pulse", tx_start, 0);
        repeat (dly) tick();
        tx_busy = 1'b1;
        repeat (len) begin
            tick();
            chk(tag, "done_early", done, 0);
            chk(tag, "gnt_inflight", gnt, 0);
            chk(tag, "tx_data_hold", tx_data, eb);
        end
        tx_busy = 1'b0;
        tick();
        chk(tag, "done", done, 1);
        chk(tag, "done_id", done_id, eid);
        chk(tag, "busy_end", busy, 0);
        tick();
        chk(tag, "done_pulse", done, 0);
        chk(tag, "gnt_after_done", gnt, 0);
    endtask

    initial begin
        rst      = 1'b1;
        req      = 4'b0001;
        req_data = 32'h0;
        tx_busy  = 1'b0;
        tick();
        tick();
        chk_all_zero("reset_hold");

        // Single requester, delayed 10-cycle busy
        rst      = 1'b0;
        req_data = {24'h0, 8'h41};
        xfer("single", 4'b0001, 8'h41, 2'd0, 1, 10);
        req = 4'b0000;

        // Fresh reset so the full rotation starts at requester 0
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        req      = 4'b1111;
        req_data = {8'h33, 8'h32, 8'h31, 8'h30};
        xfer("rr0", 4'b0001, 8'h30, 2'd0, 0, 3);
        xfer("rr1", 4'b0010, 8'h31, 2'd1, 0, 3);
        xfer("rr2", 4'b0100, 8'h32, 2'd2, 0, 3);
        xfer("rr3", 4'b1000, 8'h33, 2'd3, 0, 3);
        xfer("rr4", 4'b0001, 8'h30, 2'd0, 0, 3);

        // Wrap-around after a grant to 2
        req = 4'b0100;
        xfer("pre_wrap", 4'b0100, 8'h32, 2'd2, 0, 3);
        req = 4'b0101;
        xfer("wrap", 4'b0001, 8'h30, 2'd0, 0, 3);
        req = 4'b0000;

        // Transmitter busy in IDLE holds off the grant
        tx_busy = 1'b1;
        req     = 4'b0010;
        repeat (3) begin
            tick();
            chk("idle_busy", "gnt", gnt, 0);
            chk("idle_busy", "busy", busy, 0);
        end
        tx_busy = 1'b0;
        xfer("idle_busy_rel", 4'b0010, 8'h31, 2'd1, 0, 3);
        req = 4'b0000;

        // Timeout: tx_busy never rises
        req = 4'b1000;
        tick();
        chk("tmo", "gnt", gnt, 4'b1000);
        req = 4'b0000;
        tick();
        repeat (15) begin
            tick();
            chk("tmo", "err_early", err, 0);
            chk("tmo", "done", done, 0);
        end
        tick();
        chk("tmo", "err", err, 1);
        chk("tmo", "done_id", done_id, 2'd3);
        chk("tmo", "busy", busy, 0);
        chk("tmo", "done_with_err", done, 0);
        tick();
        chk("tmo", "err_pulse", err, 0);
        chk("tmo", "done_after", done, 0);

        // Reset in WAIT_DONE with requester 3 pending
        req = 4'b0010;
        tick();
        chk("rst_mid", "gnt", gnt, 4'b0010);
        req = 4'b1000;
        tick();
        tx_busy = 1'b1;
        tick();
        tick();
        chk("rst_mid", "busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid_async");
        tx_busy = 1'b0;
        tick();
        chk("rst_mid", "done_in_rst", done, 0);
        chk("rst_mid", "err_in_rst", err, 0);
        rst = 1'b0;
        xfer("rst_after", 4'b1000, 8'h33, 2'd3, 0, 3);
        req = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter: TIMEOUT, 1024, clk cycles allowed for tx_busy to rise after tx_start.
REQ-003 Port: clk  in  1  system clock; the only clock in the block.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: req  in  N_REQ  per-requester transmit request, level, held until granted.
REQ-006 Port: req_data  in  8*N_REQ  byte per requester; requester i uses bits [8i+7:8i].
REQ-007 Port: gnt  out  N_REQ  one-hot, one-cycle grant pulse; byte captured.
REQ-008 Port: tx_start  out  1  one-cycle start pulse to the transmitter.
REQ-009 Port: tx_data  out  8  registered byte to the transmitter, stable from tx_start until return to IDLE.
REQ-010 Port: tx_busy  in  1  transmitter active flag, high from start bit through stop bit.
REQ-011 Port: done  out  1  one-cycle pulse when the granted byte has finished.
REQ-012 Port: done_id  out  $clog2(N_REQ)  index of the finished or errored requester, valid with done or err.
REQ-013 Port: err  out  1  one-cycle pulse on timeout.
REQ-014 Port: busy  out  1  high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-016 In IDLE, when tx_busy=0 and any req bit is 1, the block SHALL select the winner as the first set req bit at or after ptr, searching upward with wrap-around.
REQ-017 After a grant decision in IDLE, the following cycle (LAUNCH) SHALL assert gnt[winner], tx_start and valid tx_data together, each for exactly one cycle for the pulses.
REQ-018 On a grant, the block SHALL update ptr to winner+1 modulo N_REQ.
REQ-019 LAUNCH SHALL always advance to WAIT_BUSY after one cycle.
REQ-020 In WAIT_BUSY, a 1 on tx_busy SHALL move the FSM to WAIT_DONE.
REQ-021 In WAIT_BUSY, the timeout counter SHALL clear on entry, and when it reaches TIMEOUT-1 the block SHALL pulse err and return to IDLE.
REQ-022 In WAIT_DONE, a 0 on tx_busy SHALL pulse done with done_id equal to the winner and return the FSM to IDLE.
REQ-023 Boundaries:
  - req changes while busy are ignored.
  - A req dropped before its grant is never granted.
  - A req still high after its gnt is a new request, ranked by ptr.
  - If tx_busy=1 while in IDLE, the block does not grant.
  - done and a new grant decision cannot occur in the same cycle; the earliest next gnt is 2 cycles after done.
REQ-024 The timeout counter SHALL be wide enough for TIMEOUT and SHALL never wrap.

Reset
REQ-025 While rst=1, the block SHALL hold state=IDLE, ptr=0, tx_data=0, the timeout counter at 0, and gnt, tx_start, done, done_id, err and busy all at 0.
REQ-026 Reset asserted mid-transfer SHALL abandon the transfer, produce no done or err pulse, and restart round-robin at requester 0.

Structure
REQ-027 The state encodings and the default N_REQ and TIMEOUT values SHALL live in a shared uart_defs package/include, used by all UART blocks.
REQ-028 The round-robin search SHALL be a combinational sub-module rr_pick, with inputs req and ptr and outputs any and idx.
REQ-029 All outputs SHALL be registered.

Verification
REQ-030 Reset, then req=4'b0001 with data0=8'h41, and a tx_busy model high for 10 cycles starting 2 cycles after tx_start -> gnt=0001 and tx_start in the same cycle, tx_data=8'h41 until done, done_id=0.
REQ-031 req=4'b1111 held continuously with data i = 8'h30+i -> grants issue in the order 0,1,2,3,0 with the matching bytes, and exactly one transfer is in flight at a time.
REQ-032 After a grant to 2, req=4'b0101 -> the next grant goes to 0 (wrap-around).
REQ-033 tx_busy never rises after tx_start, TIMEOUT=16 -> err pulses exactly 16 cycles after entering WAIT_BUSY, done_id equals the winner, the FSM returns to IDLE, and no done pulse occurs.
REQ-034 rst pulsed during WAIT_DONE with req=4'b1000 pending -> all outputs go to 0 immediately, and after release requester 3 is granted with ptr restarted from 0.
REQ-035 tx_busy=1 in IDLE with req=4'b0010 -> no gnt until tx_busy=0, then gnt=0010 the following cycle.
